// File: rtl/regfile_sb.sv
// ARM-style general register file with PC alias, optional writeback bypass and a
// per-register scoreboard that drives the decode-stage hazard signal.
module regfile_sb #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned NUM_REGS   = 15,
    parameter int unsigned PC_IDX     = 15,
    parameter int unsigned RESET_MODE = 1,
    parameter bit          BYPASS     = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   src1,
    input  logic [ADDR_W-1:0]   src2,
    input  logic                use1,
    input  logic                use2,
    input  logic [DATA_W-1:0]   pc_in,
    input  logic                wb_en,
    input  logic [ADDR_W-1:0]   wb_dest,
    input  logic [DATA_W-1:0]   wb_data,
    input  logic                iss_en,
    input  logic [ADDR_W-1:0]   iss_dest,
    input  logic                flush,
    output logic [DATA_W-1:0]   reg1,
    output logic [DATA_W-1:0]   reg2,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy_vec
);

    localparam logic [ADDR_W-1:0] PC_ADDR = ADDR_W'(PC_IDX);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic                wb_ok, iss_ok;
    logic                busy1, busy2, fwd1, fwd2;

    function automatic logic is_reg(input logic [ADDR_W-1:0] a);
        return (32'(a) < NUM_REGS) && (a != PC_ADDR);
    endfunction

    assign wb_ok  = wb_en && is_reg(wb_dest);
    assign iss_ok = iss_en && is_reg(iss_dest);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= (RESET_MODE == 1) ? DATA_W'(i) : '0;
            end
        end else if (wb_ok) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wb_dest == ADDR_W'(i)) begin
                    regs_q[i] <= wb_data;
                end
            end
        end
    end

    // Issue is applied after clear and flush so a newer outstanding write wins.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (wb_ok && wb_dest == ADDR_W'(r)) begin
                busy_d[r] = 1'b0;
            end
            if (iss_ok && iss_dest == ADDR_W'(r)) begin
                busy_d[r] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    always_comb begin
        reg1  = '0;
        reg2  = '0;
        busy1 = 1'b0;
        busy2 = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (src1 == ADDR_W'(r)) begin
                reg1  = regs_q[r];
                busy1 = busy_q[r];
            end
            if (src2 == ADDR_W'(r)) begin
                reg2  = regs_q[r];
                busy2 = busy_q[r];
            end
        end
        if (BYPASS && wb_ok && wb_dest == src1) begin
            reg1 = wb_data;
        end
        if (BYPASS && wb_ok && wb_dest == src2) begin
            reg2 = wb_data;
        end
        if (src1 == PC_ADDR) begin
            reg1  = pc_in;
            busy1 = 1'b0;
        end
        if (src2 == PC_ADDR) begin
            reg2  = pc_in;
            busy2 = 1'b0;
        end
    end

    assign fwd1   = BYPASS && wb_en && (wb_dest == src1);
    assign fwd2   = BYPASS && wb_en && (wb_dest == src2);
    assign hazard = (use1 && busy1 && !fwd1) || (use2 && busy2 && !fwd2);

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: one bypassing instance and one non-bypassing
// instance share stimulus; expected values are hand-computed constants.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic [3:0]  src1, src2;
    logic        use1, use2;
    logic [31:0] pc_in;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic [31:0] wb_data;
    logic        iss_en;
    logic [3:0]  iss_dest;
    logic        flush;
    logic [31:0] reg1, reg2, reg1_nb, reg2_nb;
    logic        hazard, hazard_nb;
    logic [14:0] busy_vec, busy_vec_nb;

    int checks   = 0;
    int failures = 0;

    regfile_sb #(.BYPASS(1'b1)) dut (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .use1(use1), .use2(use2),
        .pc_in(pc_in), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .iss_en(iss_en), .iss_dest(iss_dest), .flush(flush),
        .reg1(reg1), .reg2(reg2), .hazard(hazard), .busy_vec(busy_vec)
    );

    regfile_sb #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .src1(src1), .src2(src2), .use1(use1), .use2(use2),
        .pc_in(pc_in), .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data),
        .iss_en(iss_en), .iss_dest(iss_dest), .flush(flush),
        .reg1(reg1_nb), .reg2(reg2_nb), .hazard(hazard_nb), .busy_vec(busy_vec_nb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        use1 = 0; use2 = 0; wb_en = 0; iss_en = 0; flush = 0;
        wb_dest = 0; wb_data = 0; iss_dest = 0;
    endtask

    task automatic issue(input logic [3:0] d);
        @(negedge clk);
        idle_inputs();
        iss_en = 1; iss_dest = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; src1 = 3; src2 = 14; pc_in = 32'h100;
        idle_inputs();
        #3;
        check_eq("rst_reg1", reg1, 32'd3);
        check_eq("rst_reg2", reg2, 32'd14);
        check_eq("rst_busy", 32'(busy_vec), 32'd0);
        check_eq("rst_hazard", 32'(hazard), 32'd0);

        @(negedge clk);
        rst = 0; src1 = 15; src2 = 0;
        #1;
        check_eq("pc_read", reg1, 32'h100);
        check_eq("r0_read", reg2, 32'd0);

        // Write R5: bypass shows it immediately, non-bypass after the edge.
        @(negedge clk);
        wb_en = 1; wb_dest = 5; wb_data = 32'hDEADBEEF; src1 = 5;
        #1;
        check_eq("byp_same_cycle", reg1, 32'hDEADBEEF);
        check_eq("nobyp_old", reg1_nb, 32'd5);
        @(posedge clk);
        #1;
        check_eq("nobyp_after_edge", reg1_nb, 32'hDEADBEEF);
        @(negedge clk);
        idle_inputs();
        #1;
        check_eq("byp_stored", reg1, 32'hDEADBEEF);

        // Scoreboard and hazard on R2.
        issue(4'd2);
        @(negedge clk);
        idle_inputs();
        src1 = 2; use1 = 1;
        #1;
        check_eq("busy_r2", 32'(busy_vec), 32'h0004);
        check_eq("hazard_use", 32'(hazard), 32'd1);
        use1 = 0;
        #1;
        check_eq("hazard_nouse", 32'(hazard), 32'd0);
        use1 = 1; wb_en = 1; wb_dest = 2; wb_data = 32'h22;
        #1;
        check_eq("hazard_fwd", 32'(hazard), 32'd0);
        check_eq("hazard_nofwd", 32'(hazard_nb), 32'd1);
        @(posedge clk);
        #1;
        check_eq("busy_r2_cleared", 32'(busy_vec), 32'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check_eq("r2_written", reg1, 32'h22);

        // Simultaneous issue and writeback on R7: set wins, data lands.
        @(negedge clk);
        iss_en = 1; iss_dest = 7; wb_en = 1; wb_dest = 7; wb_data = 32'h77;
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        src1 = 7;
        #1;
        check_eq("busy_r7_set_wins", 32'(busy_vec), 32'h0080);
        check_eq("r7_written", reg1, 32'h77);

        issue(4'd1);
        issue(4'd4);
        issue(4'd9);
        check_eq("busy_multi", 32'(busy_vec), 32'h0292);

        @(negedge clk);
        idle_inputs();
        flush = 1; iss_en = 1; iss_dest = 3;
        @(posedge clk);
        #1;
        check_eq("flush_keeps_issue", 32'(busy_vec), 32'h0008);

        // PC address as writeback/issue target has no effect.
        @(negedge clk);
        idle_inputs();
        wb_en = 1; wb_dest = 15; wb_data = 32'h55; iss_en = 1; iss_dest = 15;
        src1 = 15; src2 = 14; use1 = 1;
        #1;
        check_eq("pc_no_bypass", reg1, 32'h100);
        check_eq("pc_no_hazard", 32'(hazard), 32'd0);
        @(posedge clk);
        #1;
        check_eq("pc_wb_busy", 32'(busy_vec), 32'h0008);
        check_eq("r14_unchanged", reg2, 32'd14);

        // Asynchronous reset mid-cycle with pending work.
        @(negedge clk);
        idle_inputs();
        wb_en = 1; wb_dest = 6; wb_data = 32'h66; src1 = 5; src2 = 7;
        #2;
        rst = 1;
        #1;
        check_eq("arst_busy", 32'(busy_vec), 32'd0);
        check_eq("arst_r5", reg1, 32'd5);
        check_eq("arst_r7", reg2, 32'd7);
        @(negedge clk);
        idle_inputs();
        rst = 0; src1 = 3; use1 = 1; src2 = 6;
        #1;
        check_eq("arst_hazard", 32'(hazard), 32'd0);
        check_eq("arst_r6_lost", reg2, 32'd6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
